// File: rtl/motor_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// motor_ctrl_pkg
//   Shared definitions for the motor fault-response slice: FSM state
//   encodings (also driven out on fsm_state), default timing/retry constants
//   and a small helper that tells whether a state drives the motor.
//
//   Optional feature macro: SOFT_START_EN (adds the RAMP state's logic in the
//   top and in pwm_gen; the encoding below is always reserved).
// ---------------------------------------------------------------------------
package motor_ctrl_pkg;

  // Encodings are visible on the fsm_state port, keep them stable.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_SHUTDOWN = 3'd2,
    ST_LOCKOUT  = 3'd3,
    ST_RAMP     = 3'd4
  } state_e;

  localparam int DEF_PWM_BITS        = 8;
  localparam int DEF_COOLDOWN_CYCLES = 1000;
  localparam int DEF_MAX_RETRIES     = 3;
  localparam int DEF_HEALTHY_CYCLES  = 5000;
  localparam int DEF_RAMP_DIV        = 16;

  // States in which the driver is enabled and PWM may toggle.
  function automatic logic is_drive_state(state_e s);
    return (s == ST_RUN) || (s == ST_RAMP);
  endfunction

endpackage

// File: rtl/motor_fault_response_pwm_gen.sv
// ---------------------------------------------------------------------------
// pwm_gen
//   Free-running PWM generator owned by motor_fault_response so that fault
//   gating of the output is cycle-exact.
//
//   The PWM_BITS counter wraps 2**PWM_BITS-1 -> 0 regardless of gate. The
//   effective duty is reloaded from duty_cmd only on the wrap cycle, so a
//   duty change never produces a runt pulse mid-period.
//   pwm_out is registered: pwm_out <= gate & (cnt < duty_eff).
//
//   Optional feature macro: SOFT_START_EN. When defined, three extra inputs
//   let the parent ramp duty_eff up from 0 instead of loading it at wrap,
//   and duty_eff is exported so the parent can see when the ramp is done.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   duty_cmd    in   requested duty (PWM_BITS)
//   gate        in   1 = output allowed to go high on the next edge
//   ramp_hold   in   (SOFT_START_EN) force duty_eff to 0
//   ramp_active in   (SOFT_START_EN) ramp owns duty_eff, wrap load suppressed
//   ramp_step   in   (SOFT_START_EN) advance duty_eff by one toward duty_cmd
//   duty_eff    out  (SOFT_START_EN) current effective duty
//   pwm_out     out  registered PWM output
// ---------------------------------------------------------------------------
module pwm_gen
  import motor_ctrl_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_cmd,
  input  logic                gate,
`ifdef SOFT_START_EN
  input  logic                ramp_hold,
  input  logic                ramp_active,
  input  logic                ramp_step,
  output logic [PWM_BITS-1:0] duty_eff,
`endif
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] cnt;
  logic                wrap;

`ifndef SOFT_START_EN
  logic [PWM_BITS-1:0] duty_eff;
`endif

  assign wrap = (cnt == {PWM_BITS{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      duty_eff <= '0;
      pwm_out  <= 1'b0;
    end else begin
      // Natural wrap of the period counter is the intended behaviour.
      cnt     <= cnt + 1'b1;
      // Strict less-than: duty 0 never high, full-scale duty high 2**N-1 of 2**N.
      pwm_out <= gate && (cnt < duty_eff);
`ifdef SOFT_START_EN
      if (ramp_hold) begin
        duty_eff <= '0;
      end else if (ramp_active) begin
        // A command drop during the ramp clamps at once; otherwise climb.
        if (duty_eff > duty_cmd) begin
          duty_eff <= duty_cmd;
        end else if (ramp_step && (duty_eff < duty_cmd)) begin
          duty_eff <= duty_eff + 1'b1;
        end
      end else if (wrap) begin
        duty_eff <= duty_cmd;
      end
`else
      if (wrap) begin
        duty_eff <= duty_cmd;
      end
`endif
    end
  end

endmodule

// File: rtl/motor_fault_response.sv
// ---------------------------------------------------------------------------
// motor_fault_response
//   Sits between the fault detector and the motor driver pins. Gates motor
//   PWM on fault, times a fault-free cooldown, retries a bounded number of
//   times and then latches a lockout until an operator clear.
//
//   Optional feature macro: SOFT_START_EN. When defined, entry from IDLE and
//   every automatic restart pass through RAMP, where the effective duty
//   climbs from 0 by one step every RAMP_DIV clocks until it meets duty_cmd.
//   When undefined the RAMP state and its logic are absent and entry goes
//   straight to RUN.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   enable_cmd     in   level, 1 = motor requested on
//   duty_cmd       in   requested duty (PWM_BITS)
//   fault_in       in   level, fault_detected from the fault detector
//   clear_lockout  in   pulse, operator clear of LOCKOUT
//   pwm_out        out  registered PWM to the driver
//   motor_enable   out  driver enable, 1 only in RUN (and RAMP)
//   fsm_state      out  current state encoding (motor_ctrl_pkg::state_e)
//   retry_cnt      out  automatic restarts used
//   lockout        out  1 while in LOCKOUT
//   restart_pulse  out  one-cycle pulse on each automatic restart
// ---------------------------------------------------------------------------
module motor_fault_response
  import motor_ctrl_pkg::*;
#(
  parameter int PWM_BITS        = DEF_PWM_BITS,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int MAX_RETRIES     = DEF_MAX_RETRIES,
`ifdef SOFT_START_EN
  parameter int RAMP_DIV        = DEF_RAMP_DIV,
`endif
  parameter int HEALTHY_CYCLES  = DEF_HEALTHY_CYCLES
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable_cmd,
  input  logic [PWM_BITS-1:0]                duty_cmd,
  input  logic                               fault_in,
  input  logic                               clear_lockout,
  output logic                               pwm_out,
  output logic                               motor_enable,
  output logic [2:0]                         fsm_state,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic                               lockout,
  output logic                               restart_pulse
);

  localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);
  localparam int COOL_W    = $clog2(COOLDOWN_CYCLES + 1);
  localparam int HEALTHY_W = $clog2(HEALTHY_CYCLES + 1);

  // COOLDOWN_CYCLES and HEALTHY_CYCLES are expected to be >= 1.
  localparam logic [COOL_W-1:0]    COOL_LAST    = COOL_W'(COOLDOWN_CYCLES - 1);
  localparam logic [HEALTHY_W-1:0] HEALTHY_MAX  = HEALTHY_W'(HEALTHY_CYCLES);
  localparam logic [HEALTHY_W-1:0] HEALTHY_LAST = HEALTHY_W'(HEALTHY_CYCLES - 1);
  localparam logic [RETRY_W-1:0]   RETRY_MAX    = RETRY_W'(MAX_RETRIES);

`ifdef SOFT_START_EN
  localparam state_e ENTRY_STATE = ST_RAMP;
`else
  localparam state_e ENTRY_STATE = ST_RUN;
`endif

  state_e              state;
  logic [COOL_W-1:0]   cooldown_cnt;
  logic [HEALTHY_W-1:0] healthy_cnt;
  logic                gate;

  assign fsm_state = state;

  // The gate is decided from the same inputs the FSM samples this cycle, so
  // a fault (or enable drop) seen at an edge zeroes pwm_out at that very edge,
  // together with the registered motor_enable.
  assign gate = is_drive_state(state) && enable_cmd && !fault_in;

`ifdef SOFT_START_EN
  localparam int RDIV_W = $clog2(RAMP_DIV + 1);
  localparam logic [RDIV_W-1:0] RDIV_LAST = RDIV_W'(RAMP_DIV - 1);

  logic [PWM_BITS-1:0] duty_eff;
  logic [RDIV_W-1:0]   ramp_div_cnt;
  logic                ramp_step;
  logic                ramp_done;

  assign ramp_step = (state == ST_RAMP) && (ramp_div_cnt == RDIV_LAST);
  // Done when the ramp already meets the command (or was clamped above it),
  // or when this edge's step lands exactly on it.
  assign ramp_done = (duty_eff >= duty_cmd) ||
                     (ramp_step && ((duty_eff + 1'b1) == duty_cmd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp_div_cnt <= '0;
    end else if ((state != ST_RAMP) || ramp_step) begin
      ramp_div_cnt <= '0;
    end else begin
      ramp_div_cnt <= ramp_div_cnt + 1'b1;
    end
  end
`endif

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gen (
    .clk         (clk),
    .rst         (rst),
    .duty_cmd    (duty_cmd),
    .gate        (gate),
`ifdef SOFT_START_EN
    .ramp_hold   (!is_drive_state(state)),
    .ramp_active (state == ST_RAMP),
    .ramp_step   (ramp_step),
    .duty_eff    (duty_eff),
`endif
    .pwm_out     (pwm_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      motor_enable  <= 1'b0;
      retry_cnt     <= '0;
      lockout       <= 1'b0;
      restart_pulse <= 1'b0;
      cooldown_cnt  <= '0;
      healthy_cnt   <= '0;
    end else begin
      restart_pulse <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (enable_cmd && !fault_in) begin
            state        <= ENTRY_STATE;
            motor_enable <= 1'b1;
            healthy_cnt  <= '0;
          end
        end

        ST_RUN: begin
          // Fault outranks an enable drop.
          if (fault_in) begin
            state        <= ST_SHUTDOWN;
            motor_enable <= 1'b0;
            cooldown_cnt <= '0;
          end else if (!enable_cmd) begin
            state        <= ST_IDLE;
            motor_enable <= 1'b0;
            retry_cnt    <= '0;
          end else if (healthy_cnt != HEALTHY_MAX) begin
            // Saturating: retry_cnt is forgiven once per continuous healthy run.
            healthy_cnt <= healthy_cnt + 1'b1;
            if (healthy_cnt == HEALTHY_LAST) begin
              retry_cnt <= '0;
            end
          end
        end

`ifdef SOFT_START_EN
        ST_RAMP: begin
          if (fault_in) begin
            state        <= ST_SHUTDOWN;
            motor_enable <= 1'b0;
            cooldown_cnt <= '0;
          end else if (!enable_cmd) begin
            state        <= ST_IDLE;
            motor_enable <= 1'b0;
            retry_cnt    <= '0;
          end else if (ramp_done) begin
            state       <= ST_RUN;
            healthy_cnt <= '0;
          end
        end
`endif

        ST_SHUTDOWN: begin
          // Only fault-free cycles count; any fault restarts the cooldown.
          if (fault_in) begin
            cooldown_cnt <= '0;
          end else if (cooldown_cnt == COOL_LAST) begin
            cooldown_cnt <= '0;
            if (!enable_cmd) begin
              state     <= ST_IDLE;
              retry_cnt <= '0;
            end else if (retry_cnt == RETRY_MAX) begin
              state   <= ST_LOCKOUT;
              lockout <= 1'b1;
            end else begin
              state         <= ENTRY_STATE;
              motor_enable  <= 1'b1;
              retry_cnt     <= retry_cnt + 1'b1;
              restart_pulse <= 1'b1;
              healthy_cnt   <= '0;
            end
          end else begin
            cooldown_cnt <= cooldown_cnt + 1'b1;
          end
        end

        ST_LOCKOUT: begin
          // A clear that arrives during a fault is dropped, not queued.
          if (clear_lockout && !fault_in) begin
            state     <= ST_IDLE;
            lockout   <= 1'b0;
            retry_cnt <= '0;
          end
        end

        default: begin
          state        <= ST_IDLE;
          motor_enable <= 1'b0;
          lockout      <= 1'b0;
        end
      endcase
    end
  end

endmodule
